// File: rtl/ram_bus_master.sv
// Bus-cycle controller for the 4-bit multiplexed RAM bus: owns the 8-phase frame, sync and cmd_n.
// Define RAM_BUS_STATS_EN to build the wr_count/rd_count transaction counters.
//
// state   | meaning
// ST_IDLE | no bus activity this frame
// ST_SRC  | send {0,chip,reg} in cycle 6, character in cycle 7
// ST_WRM  | write opcode in cycle 4, write nibble in cycle 6
// ST_RDM  | read opcode in cycle 4, RAM drives the bus in cycle 6
module ram_bus_master #(
    parameter logic [3:0] RD_OPCODE = 4'h9,
    parameter logic [3:0] WR_OPCODE = 4'h0
) (
    input  logic       clock,
    input  logic       reset_n,
    inout  wire  [3:0] data,
    output logic       sync,
    output logic       cmd_n,
    output logic [2:0] cycle,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_op,
    input  logic       req_chip,
    input  logic [1:0] req_reg,
    input  logic [3:0] req_char,
    input  logic [3:0] req_data,
    output logic       rsp_valid,
    output logic [3:0] rsp_data,
    output logic       err,
    output logic [7:0] wr_count,
    output logic [7:0] rd_count
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SRC  = 2'd1;
    localparam logic [1:0] ST_WRM  = 2'd2;
    localparam logic [1:0] ST_RDM  = 2'd3;

    logic [1:0] op;
    logic       chip_q;
    logic [1:0] reg_q;
    logic [3:0] char_q;
    logic [3:0] wdata_q;
    logic       src_done;
    logic       frame_end;
    logic       accept;
    logic       mem_op;
    logic       wr_active;
    logic       rd_active;
    logic       drive;
    logic [3:0] data_out;
    logic [1:0] next_op;

    assign frame_end = (cycle == 3'd7);
    assign req_ready = frame_end;
    assign accept    = req_valid && req_ready;
    assign mem_op    = (op == ST_WRM) || (op == ST_RDM);
    // WRM/RDM without a prior SRC have no target address, so they run as idle frames.
    assign wr_active = (op == ST_WRM) && src_done;
    assign rd_active = (op == ST_RDM) && src_done;

    always_comb begin
        next_op = ST_IDLE;
        case (req_op)
            2'd0:    next_op = ST_SRC;
            2'd1:    next_op = ST_WRM;
            2'd2:    next_op = ST_RDM;
            default: next_op = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cycle    <= 3'd0;
            op       <= ST_IDLE;
            chip_q   <= 1'b0;
            reg_q    <= 2'd0;
            char_q   <= 4'h0;
            wdata_q  <= 4'h0;
            src_done <= 1'b0;
            rsp_data <= 4'h0;
        end else begin
            cycle <= cycle + 3'd1;
            if (frame_end) begin
                op <= accept ? next_op : ST_IDLE;
                if (op == ST_SRC)
                    src_done <= 1'b1;
            end
            if (accept) begin
                chip_q  <= req_chip;
                reg_q   <= req_reg;
                char_q  <= req_char;
                wdata_q <= req_data;
            end
            if (rd_active && cycle == 3'd6)
                rsp_data <= data;
        end
    end

    always_comb begin
        cmd_n    = 1'b1;
        drive    = 1'b0;
        data_out = 4'h0;
        case (op)
            ST_SRC: begin
                if (cycle == 3'd6) begin
                    cmd_n    = 1'b0;
                    drive    = 1'b1;
                    data_out = {1'b0, chip_q, reg_q};
                end else if (cycle == 3'd7) begin
                    drive    = 1'b1;
                    data_out = char_q;
                end
            end
            ST_WRM: begin
                if (wr_active && cycle == 3'd4) begin
                    cmd_n    = 1'b0;
                    drive    = 1'b1;
                    data_out = WR_OPCODE;
                end else if (wr_active && cycle == 3'd6) begin
                    drive    = 1'b1;
                    data_out = wdata_q;
                end
            end
            ST_RDM: begin
                if (rd_active && cycle == 3'd4) begin
                    cmd_n    = 1'b0;
                    drive    = 1'b1;
                    data_out = RD_OPCODE;
                end
            end
            default: begin
                cmd_n = 1'b1;
            end
        endcase
    end

    assign data      = drive ? data_out : 4'bz;
    assign sync      = frame_end;
    assign rsp_valid = frame_end && rd_active;
    assign err       = frame_end && mem_op && !src_done;

`ifdef RAM_BUS_STATS_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_count <= 8'h00;
            rd_count <= 8'h00;
        end else if (cycle == 3'd6) begin
            if (wr_active)
                wr_count <= wr_count + 8'h01;
            if (rd_active)
                rd_count <= rd_count + 8'h01;
        end
    end
`else
    assign wr_count = 8'h00;
    assign rd_count = 8'h00;
`endif

endmodule

// File: doc/ram_bus_master.md
Name: ram_bus_master

Overview:
- Bus-cycle controller for the 4-bit multiplexed RAM bus (data, sync, cmd_n).
- Owns the free-running 8-phase frame counter and generates sync and cmd_n.
- Executes SRC, WRM and RDM transactions for a single requester through a valid/ready handshake.
- Sits between core/debug logic and one or more RAM chips on the shared bus. Each frame carries at most one transaction.

Parameters:
- RD_OPCODE, 4'h9, nibble driven in cycle 4 of an RDM frame.
- WR_OPCODE, 4'h0, nibble driven in cycle 4 of a WRM frame.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- data  inout  4  shared RAM data bus.
- sync  out  1  frame marker, high while cycle==7.
- cmd_n  out  1  active-low command strobe to RAM chips.
- cycle  out  3  current frame phase, 0..7.
- req_valid  in  1  request present.
- req_ready  out  1  high while cycle==7; a transfer occurs when req_valid && req_ready.
- req_op  in  2  request type: 0=SRC, 1=WRM, 2=RDM, 3=reserved (treated as IDLE).
- req_chip  in  1  SRC chip select bit (matches the RAM's p0 strap).
- req_reg  in  2  SRC register address.
- req_char  in  4  SRC character address.
- req_data  in  4  WRM write nibble.
- rsp_valid  out  1  one-cycle pulse during cycle 7 of a completed RDM frame.
- rsp_data  out  4  read nibble, held until the next RDM completes.
- err  out  1  one-cycle pulse during cycle 7 when a WRM/RDM was rejected.
- wr_count  out  8  writes completed (optional feature).
- rd_count  out  8  reads completed (optional feature).

Behaviour:
- Reset (asynchronous assert, synchronous-release semantics inside the block). Values:
  - cycle=0
  - frame op=IDLE
  - cmd_n=1, sync=0, data tri-stated
  - rsp_valid=0, rsp_data=0, err=0
  - src_done=0, counters=0
- Reset mid-frame abandons the transaction; no rsp_valid or err is produced.
- Frame counter: cycle increments every clock and wraps 7->0. sync=(cycle==7). The RAM's counter starts at 0 on the same release edge, so the two stay aligned.
- Handshake:
  - The op is latched at the clock edge ending cycle 7 (entering cycle 0) if req_valid && req_ready.
  - Request fields are captured at that edge. Requester inputs are ignored at all other times.
  - No transfer at that edge means the frame op is IDLE.
- Frame op states: IDLE, SRC, WRM, RDM. An op lives exactly one frame, then returns to IDLE unless a new op is accepted.
- IDLE frame: cmd_n=1 all cycles; data tri-stated.
- SRC frame:
  - cycle 6: cmd_n=0, data={1'b0, chip, reg}.
  - cycle 7: cmd_n=1, data=char.
  - Tri-stated elsewhere.
  - Sets src_done=1 at the end of cycle 7.
- WRM frame:
  - cycle 4: cmd_n=0, data=WR_OPCODE.
  - cycle 6: cmd_n=1, data=req_data.
  - Tri-stated elsewhere. wr_count increments at the end of cycle 6.
- RDM frame:
  - cycle 4: cmd_n=0, data=RD_OPCODE.
  - cycle 6: data tri-stated (the RAM drives the bus); data is sampled into rsp_data at the edge ending cycle 6.
  - cycle 7: rsp_valid=1. rd_count increments at the end of cycle 6.
- cmd_n is low only in the cycles listed above. The master never drives data while cmd_n=0 in cycle 4 of an IDLE frame.
- Precondition guard: a WRM/RDM accepted while src_done=0 runs as an IDLE frame (no bus activity) and pulses err in cycle 7. SRC is always accepted.
- req_op=3 is accepted (consumes the handshake), runs as IDLE, and raises no err.
- Back-to-back requests are accepted every frame; the maximum rate is one transaction per 8 clocks.
- Counters wrap 255->0.

Optional Feature:
- RAM_BUS_STATS_EN defined: wr_count/rd_count count completed WRM/RDM frames as above; rejected ops are not counted.
- RAM_BUS_STATS_EN undefined: counter logic is omitted and wr_count/rd_count are tied to 8'h0. The ports remain in all builds.

Test Plan:
- Reset released, no requests, 16 clocks: cycle steps 0..7,0..7; sync high only at cycles 7 and 15; cmd_n=1 and data=Z throughout.
- RDM issued before any SRC: err pulses in cycle 7; no cmd_n low; rsp_valid stays 0; rd_count=0.
- SRC (chip=0, reg=2, char=5), then WRM data=4'hA, then RDM, against one RAM with p0=0:
  - frame 1: cycle 6 data=4'h2 with cmd_n=0; cycle 7 data=4'h5.
  - frame 2: cycle 4 data=4'h0 with cmd_n=0.
  - frame 3: rsp_data=4'hA, rsp_valid in cycle 7.
  - wr_count=1, rd_count=1.
- SRC chip=1 to a RAM strapped p0=0, then RDM: the RAM is deselected and the bus floats in cycle 6; rsp_valid still pulses; no error from the master.
- reset_n pulsed low during cycle 5 of a WRM frame: outputs return to reset values immediately; the memory location is not written; the next frame starts at cycle 0 with src_done=0.
- Build without RAM_BUS_STATS_EN, run 3 WRMs: bus behaviour identical; wr_count=0.
